// File: rtl/vga_frame_tracker.sv
// 640x480@60 VGA timing generator with registered sync/video decodes and a
// frame_tik level covering the vertical front porch for game-state updates.
module vga_frame_tracker #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clock_25,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_tik,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_OVER     = 10'(V_TOTAL);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       x_wrap;
    logic       frame_end;

    // Out-of-range values (>= total) fall back to 0 on the next edge.
    always_comb begin
        x_wrap    = (pixel_x >= H_LAST);
        frame_end = x_wrap && (pixel_y == V_LAST);
        x_next    = x_wrap ? 10'd0 : pixel_x + 10'd1;
        y_next    = pixel_y;
        if (pixel_y >= V_OVER) begin
            y_next = 10'd0;
        end else if (x_wrap) begin
            y_next = (pixel_y >= V_LAST) ? 10'd0 : pixel_y + 10'd1;
        end
    end

    // Outputs decode the next counter value so they line up with the counters.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_tik   <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            pixel_x   <= x_next;
            pixel_y   <= y_next;
            video_on  <= (x_next < H_VIS_END) && (y_next < V_VIS_END);
            hsync     <= !((x_next >= HS_START) && (x_next < HS_END));
            vsync     <= !((y_next >= VS_START) && (y_next < VS_END));
            frame_tik <= (y_next >= V_VIS_END) && (y_next < VS_START);
            if (frame_end) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_tracker.sv
// Directed bench: full-size instance for line timing, a scaled-down instance
// (16x12 total) for frame, frame_tik, wrap and mid-frame reset behaviour.
module tb_vga_frame_tracker;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       reset;
    logic       d_hsync, d_vsync, d_video_on, d_frame_tik;
    logic [9:0] d_pixel_x, d_pixel_y;
    logic [7:0] d_frame_count;
    logic       s_hsync, s_vsync, s_video_on, s_frame_tik;
    logic [9:0] s_pixel_x, s_pixel_y;
    logic [7:0] s_frame_count;

    vga_frame_tracker dut_full (
        .clock_25   (clk),
        .reset      (reset),
        .hsync      (d_hsync),
        .vsync      (d_vsync),
        .video_on   (d_video_on),
        .pixel_x    (d_pixel_x),
        .pixel_y    (d_pixel_y),
        .frame_tik  (d_frame_tik),
        .frame_count(d_frame_count)
    );

    // Small geometry: H 8+2+3+3=16, V 6+2+2+2=12, frame = 192 clocks.
    vga_frame_tracker #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_small (
        .clock_25   (clk),
        .reset      (reset),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .video_on   (s_video_on),
        .pixel_x    (s_pixel_x),
        .pixel_y    (s_pixel_y),
        .frame_tik  (s_frame_tik),
        .frame_count(s_frame_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int d_hs_cnt, d_hs_min, d_hs_max, d_vo_cnt, d_vo_max;
        int s_vs_cnt, s_vo_cnt, s_tik_cnt, s_rise, s_fall;
        int s_first_rise, s_first_fall, s_tik_bad;
        logic s_prev_tik;
        int k;

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (37) step();

        reset = 1'b1;
        repeat (5) step();
        check("rst_d_x", int'(d_pixel_x), 0);
        check("rst_d_y", int'(d_pixel_y), 0);
        check("rst_d_hsync", int'(d_hsync), 1);
        check("rst_d_vsync", int'(d_vsync), 1);
        check("rst_d_video_on", int'(d_video_on), 0);
        check("rst_d_frame_tik", int'(d_frame_tik), 0);
        check("rst_d_frame_count", int'(d_frame_count), 0);
        check("rst_s_x", int'(s_pixel_x), 0);
        check("rst_s_y", int'(s_pixel_y), 0);
        check("rst_s_frame_tik", int'(s_frame_tik), 0);
        check("rst_s_frame_count", int'(s_frame_count), 0);

        d_hs_cnt = 0; d_hs_min = 9999; d_hs_max = -1; d_vo_cnt = 0; d_vo_max = -1;
        s_vs_cnt = 0; s_vo_cnt = 0; s_tik_cnt = 0; s_rise = 0; s_fall = 0;
        s_first_rise = -1; s_first_fall = -1; s_tik_bad = 0;
        s_prev_tik = s_frame_tik;

        reset = 1'b0;
        n = 0;
        while (n < 1600) begin
            step();
            n++;
            if (!d_hsync) begin
                d_hs_cnt++;
                if (int'(d_pixel_x) < d_hs_min) d_hs_min = int'(d_pixel_x);
                if (int'(d_pixel_x) > d_hs_max) d_hs_max = int'(d_pixel_x);
            end
            if (d_video_on) begin
                d_vo_cnt++;
                if (int'(d_pixel_x) > d_vo_max) d_vo_max = int'(d_pixel_x);
            end
            if (n == 1) begin
                check("d_first_x", int'(d_pixel_x), 1);
                check("d_first_video_on", int'(d_video_on), 1);
            end
            if (n == 799) begin
                check("d_eol_x", int'(d_pixel_x), 799);
                check("d_eol_y", int'(d_pixel_y), 0);
            end
            if (n == 800) begin
                check("d_line1_x", int'(d_pixel_x), 0);
                check("d_line1_y", int'(d_pixel_y), 1);
            end
            if (n <= 576) begin
                if (!s_vsync) s_vs_cnt++;
                if (s_video_on) s_vo_cnt++;
                if (s_frame_tik) s_tik_cnt++;
                if (s_frame_tik && !s_prev_tik) begin
                    s_rise++;
                    if (s_first_rise < 0) s_first_rise = n;
                end
                if (!s_frame_tik && s_prev_tik) begin
                    s_fall++;
                    if (s_first_fall < 0) s_first_fall = n;
                end
                if (s_frame_tik !== (s_pixel_y >= 10'd6 && s_pixel_y < 10'd8)) s_tik_bad++;
                s_prev_tik = s_frame_tik;
            end
            if (n == 191) begin
                check("s_frame_end_x", int'(s_pixel_x), 15);
                check("s_frame_end_y", int'(s_pixel_y), 11);
                check("s_fc_before", int'(s_frame_count), 0);
            end
            if (n == 192) begin
                check("s_frame_start_y", int'(s_pixel_y), 0);
                check("s_fc_after", int'(s_frame_count), 1);
            end
        end
        check("d_line2_y", int'(d_pixel_y), 2);
        check("d_hsync_low_clocks", d_hs_cnt, 192);
        check("d_hsync_first_x", d_hs_min, 656);
        check("d_hsync_last_x", d_hs_max, 751);
        check("d_video_on_clocks", d_vo_cnt, 1280);
        check("d_video_on_last_x", d_vo_max, 639);
        check("s_vsync_low_clocks", s_vs_cnt, 96);
        check("s_video_on_clocks", s_vo_cnt, 144);
        check("s_tik_high_clocks", s_tik_cnt, 96);
        check("s_tik_rises", s_rise, 3);
        check("s_tik_falls", s_fall, 3);
        check("s_tik_first_rise", s_first_rise, 96);
        check("s_tik_first_fall", s_first_fall, 128);
        check("s_tik_vs_line", s_tik_bad, 0);

        while (n < 49151) begin
            step();
            n++;
        end
        check("wrap_fc_255", int'(s_frame_count), 255);
        check("wrap_x_last", int'(s_pixel_x), 15);
        step();
        n++;
        check("wrap_fc_0", int'(s_frame_count), 0);
        check("wrap_y_0", int'(s_pixel_y), 0);

        while (n < 49152 + 7 * 16 + 5) begin
            step();
            n++;
        end
        check("mid_pre_y", int'(s_pixel_y), 7);
        check("mid_pre_tik", int'(s_frame_tik), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_tik_cut", int'(s_frame_tik), 0);
        check("mid_x", int'(s_pixel_x), 0);
        check("mid_y", int'(s_pixel_y), 0);
        check("mid_fc", int'(s_frame_count), 0);
        check("mid_vsync", int'(s_vsync), 1);
        check("mid_d_x", int'(d_pixel_x), 0);

        k = 0;
        while (!s_frame_tik && k < 1000) begin
            step();
            k++;
        end
        check("mid_next_rise_clocks", k, 96);
        check("mid_rise_x", int'(s_pixel_x), 0);
        check("mid_rise_y", int'(s_pixel_y), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
